// File: rtl/clk_mon.sv
// clk_mon: measures a monitored clock against the reference clock i_clk.
// The monitored clock is sampled as plain data. Its period and high time are
// counted in i_clk cycles, and each period is checked against
// EXP_PERIOD +/- TOL. The block reports lock, bad periods and a stopped clock.
module clk_mon #(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 8,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_mon_clk,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_period_vld,
    output logic             o_locked,
    output logic             o_stopped,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ACQ     = 3'd1;
    localparam logic [2:0] ST_MEAS    = 3'd2;
    localparam logic [2:0] ST_LOCKED  = 3'd3;
    localparam logic [2:0] ST_STOPPED = 3'd4;

    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAXV  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] P_LO  = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] P_HI  = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] T_OUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] L_M1  = CNT_W'(LOCK_CNT - 1);

    logic [2:0]       state;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] per_cnt, hi_cnt, good_cnt;
    logic             per_good, timed_out;

    assign rise      = s2 & ~s3;
    // A saturated count means the real period is unknown, so it can never be good.
    assign per_good  = (per_cnt >= P_LO) && (per_cnt <= P_HI) && (per_cnt != MAXV);
    assign timed_out = (per_cnt >= T_OUT);

    // Two-flop synchronizer plus one delay flop used for rising-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i_mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Period and high-time counters. They restart at 1 on each edge, so the
    // edge cycle itself counts toward the next interval.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (!i_en || state == ST_IDLE) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= ONE;
            hi_cnt  <= ONE;
        end else begin
            if (per_cnt != MAXV)
                per_cnt <= per_cnt + ONE;
            if (s2 && hi_cnt != MAXV)
                hi_cnt <= hi_cnt + ONE;
        end
    end

    // Control FSM with registered status outputs. Disable takes priority over
    // every other event. An edge in the same cycle as a timeout is treated as
    // an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            good_cnt     <= '0;
            o_period     <= '0;
            o_high       <= '0;
            o_period_vld <= 1'b0;
            o_locked     <= 1'b0;
            o_stopped    <= 1'b0;
            o_err        <= 1'b0;
            o_err_cnt    <= '0;
        end else begin
            o_period_vld <= 1'b0;
            o_err        <= 1'b0;
            if (!i_en) begin
                state     <= ST_IDLE;
                good_cnt  <= '0;
                o_locked  <= 1'b0;
                o_stopped <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_ACQ;
                    ST_ACQ: begin
                        // The first edge only aligns the counters; nothing is reported.
                        if (rise) begin
                            state <= ST_MEAS;
                        end else if (timed_out) begin
                            state     <= ST_STOPPED;
                            o_stopped <= 1'b1;
                            o_err     <= 1'b1;
                            if (o_err_cnt != MAXV)
                                o_err_cnt <= o_err_cnt + ONE;
                        end
                    end
                    ST_MEAS, ST_LOCKED: begin
                        if (rise) begin
                            o_period     <= per_cnt;
                            o_high       <= hi_cnt;
                            o_period_vld <= 1'b1;
                            if (per_good) begin
                                if (good_cnt != MAXV)
                                    good_cnt <= good_cnt + ONE;
                                if (state == ST_MEAS && good_cnt >= L_M1) begin
                                    state    <= ST_LOCKED;
                                    o_locked <= 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                                state    <= ST_MEAS;
                                o_locked <= 1'b0;
                                o_err    <= 1'b1;
                                if (o_err_cnt != MAXV)
                                    o_err_cnt <= o_err_cnt + ONE;
                            end
                        end else if (timed_out) begin
                            good_cnt  <= '0;
                            state     <= ST_STOPPED;
                            o_stopped <= 1'b1;
                            o_locked  <= 1'b0;
                            o_err     <= 1'b1;
                            if (o_err_cnt != MAXV)
                                o_err_cnt <= o_err_cnt + ONE;
                        end
                    end
                    ST_STOPPED: begin
                        // The interval that ends on this edge spans the outage,
                        // so it is dropped and measurement restarts from here.
                        if (rise) begin
                            state     <= ST_MEAS;
                            o_stopped <= 1'b0;
                            good_cnt  <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_mon.sv
// tb_clk_mon: directed checks of clk_mon covering lock, bad periods, tolerance,
// stop/resume, duty cycle, disable and asynchronous reset.
module tb_clk_mon;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_en = 1'b0;
    logic        i_mon_clk = 1'b0;
    logic [15:0] o_period, o_high, o_err_cnt;
    logic        o_period_vld, o_locked, o_stopped, o_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Settings for the monitored-clock generator.
    bit mon_run = 1'b0;
    bit mon_alt = 1'b0;
    int mon_hi = 40;
    int stretch_req = 0;

    // Counters for the event monitor.
    int cyc = 0, err_seen = 0, vld_seen = 0, last_vld_cyc = 0, stop_cyc = 0;
    bit stop_q = 1'b0;

    clk_mon dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_mon_clk(i_mon_clk),
        .o_period(o_period), .o_high(o_high), .o_period_vld(o_period_vld),
        .o_locked(o_locked), .o_stopped(o_stopped), .o_err(o_err),
        .o_err_cnt(o_err_cnt)
    );

    // 10 ns reference clock with rising edges at 5 mod 10.
    always #5 i_clk = ~i_clk;

    // Monitored clock with edges at 3 mod 10, well away from the i_clk rising edges.
    initial begin : mon_gen
        int per;
        int stretch_done;
        bit alt_phase;
        stretch_done = 0;
        alt_phase = 1'b0;
        #3;
        forever begin
            if (!mon_run) begin
                i_mon_clk = 1'b0;
                #10;
            end else begin
                per = 80;
                if (stretch_req != stretch_done) begin
                    per = 110;
                    stretch_done++;
                end else if (mon_alt) begin
                    per = alt_phase ? 90 : 70;
                    alt_phase = !alt_phase;
                end
                i_mon_clk = 1'b1;
                #(mon_hi);
                i_mon_clk = 1'b0;
                #(per - mon_hi);
            end
        end
    end

    // Event monitor: counts error and valid pulses and time-stamps them in cycles.
    always @(negedge i_clk) begin
        cyc++;
        if (o_err) err_seen++;
        if (o_period_vld) begin
            vld_seen++;
            last_vld_cyc = cyc;
        end
        if (o_stopped && !stop_q) stop_cyc = cyc;
        stop_q = o_stopped;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_period_vld && n < 300);
        chk({tag, "_vld_seen"}, 32'(o_period_vld), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, 32'(o_period), 0);
        chk({tag, "_high"}, 32'(o_high), 0);
        chk({tag, "_vld"}, 32'(o_period_vld), 0);
        chk({tag, "_locked"}, 32'(o_locked), 0);
        chk({tag, "_stopped"}, 32'(o_stopped), 0);
        chk({tag, "_err"}, 32'(o_err), 0);
        chk({tag, "_err_cnt"}, 32'(o_err_cnt), 0);
    endtask

    initial begin : main
        int n, prev, base;
        #1 i_rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        i_en = 1'b1;
        mon_run = 1'b1;

        // Nominal 80 ns clock at 50% duty: lock on the 4th reported period.
        for (int k = 0; k < 4; k++) begin
            wait_vld("nom");
            chk("nom_period", 32'(o_period), 8);
            chk("nom_high", 32'(o_high), 4);
            chk("nom_locked", 32'(o_locked), (k == 3) ? 1 : 0);
            chk("nom_err_cnt", 32'(o_err_cnt), 0);
        end

        // A single 110 ns period: error, then lock returns after 4 good periods.
        stretch_req++;
        n = 0;
        do begin
            wait_vld("str");
            n++;
        end while (o_period == 16'd8 && n < 4);
        chk("str_period", 32'(o_period), 11);
        chk("str_err", 32'(o_err), 1);
        chk("str_err_cnt", 32'(o_err_cnt), 1);
        chk("str_locked", 32'(o_locked), 0);
        for (int k = 0; k < 4; k++) begin
            wait_vld("relock");
            chk("relock_period", 32'(o_period), 8);
            chk("relock_locked", 32'(o_locked), (k == 3) ? 1 : 0);
        end

        // Periods alternating 70/90 ns stay within tolerance.
        mon_alt = 1'b1;
        repeat (3) wait_vld("alt_skip");
        prev = 32'(o_period);
        for (int k = 0; k < 6; k++) begin
            wait_vld("alt");
            chk("alt_pair_sum", prev + 32'(o_period), 16);
            chk("alt_is_7_or_9", ((o_period == 16'd7) || (o_period == 16'd9)) ? 1 : 0, 1);
            chk("alt_locked", 32'(o_locked), 1);
            prev = 32'(o_period);
        end
        chk("alt_err_cnt", 32'(o_err_cnt), 1);
        mon_alt = 1'b0;

        // Stopped clock: declared 32 cycles after the last edge with exactly one error.
        wait_vld("pre_stop");
        #1 base = err_seen;
        mon_run = 1'b0;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_stopped && n < 300);
        chk("stop_seen", 32'(o_stopped), 1);
        #1 chk("stop_delay", stop_cyc - last_vld_cyc, 32);
        chk("stop_locked", 32'(o_locked), 0);
        repeat (40) @(negedge i_clk);
        #1 chk("stop_one_err", err_seen - base, 1);
        chk("stop_err_cnt", 32'(o_err_cnt), 2);
        chk("stop_held", 32'(o_stopped), 1);

        // Resume: the stop flag clears on the first edge, the first report comes at the second edge.
        base = vld_seen;
        mon_run = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_stopped && n < 300);
        chk("resume_cleared", 32'(o_stopped), 0);
        #1 chk("resume_no_report", vld_seen - base, 0);
        for (int k = 0; k < 4; k++) begin
            wait_vld("resume");
            chk("resume_period", 32'(o_period), 8);
            chk("resume_locked", 32'(o_locked), (k == 3) ? 1 : 0);
        end

        // Disable while locked: lock drops on the next cycle and the last period is held.
        @(negedge i_clk);
        i_en = 1'b0;
        @(negedge i_clk);
        chk("dis_locked", 32'(o_locked), 0);
        chk("dis_period_hold", 32'(o_period), 8);
        chk("dis_err_cnt_hold", 32'(o_err_cnt), 2);

        // 25% duty cycle after re-enable.
        mon_hi = 20;
        repeat (20) @(negedge i_clk);
        i_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_vld("duty");
            chk("duty_period", 32'(o_period), 8);
            chk("duty_high", 32'(o_high), 2);
            chk("duty_locked", 32'(o_locked), (k == 3) ? 1 : 0);
        end

        // Short asynchronous reset between clock edges while the monitored clock is low.
        @(negedge i_mon_clk);
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1 chk_all_zero("arst");
        #2 i_rst_n = 1'b1;
        wait_vld("post_rst");
        chk("post_rst_period", 32'(o_period), 8);
        chk("post_rst_high", 32'(o_high), 2);
        chk("post_rst_locked", 32'(o_locked), 0);
        chk("post_rst_err_cnt", 32'(o_err_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
